// File: rtl/alu_flag_unit_if.sv
// Execute-stage bus for alu_flag_unit: ALU operands/op, flag write enable,
// combinational and registered ALU outputs, and the independent PC adder.
interface alu_flag_unit_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cntrl;
    logic             flag_en;

    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    logic [WIDTH-1:0] result_q;
    logic             flag_n_q;
    logic             flag_z_q;
    logic             flag_v_q;
    logic             flag_c_q;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;

    // Driver side (ID/EX stage or bench)
    modport master (
        output a, b, cntrl, flag_en, add_a, add_b,
        input  result, negative, zero, overflow, carry_out,
        input  result_q, flag_n_q, flag_z_q, flag_v_q, flag_c_q,
        input  add_sum
    );

    // The execute block itself
    modport slave (
        input  a, b, cntrl, flag_en, add_a, add_b,
        output result, negative, zero, overflow, carry_out,
        output result_q, flag_n_q, flag_z_q, flag_v_q, flag_c_q,
        output add_sum
    );
endinterface

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU with NZVC flag generation, NZVC flag register with write
// enable, a registered copy of the ALU result, and a separate PC/branch adder.
module alu_flag_unit #(
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    alu_flag_unit_if.slave  bus
);
    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    logic [WIDTH-1:0] bOperand;
    logic             carryIn;
    logic             isArith;
    logic [WIDTH:0]   addFull;
    logic             msbCarryIn;
    logic [WIDTH-1:0] aluResult;
    logic             flagN;
    logic             flagZ;
    logic             flagV;
    logic             flagC;

    logic [WIDTH-1:0] resultReg;
    logic             flagNReg;
    logic             flagZReg;
    logic             flagVReg;
    logic             flagCReg;

    // Shared adder input selection: subtract is a + ~b + 1 so carry means "no borrow"
    always_comb begin
        bOperand = bus.b;
        carryIn  = 1'b0;
        isArith  = 1'b0;
        case (bus.cntrl)
            OP_ADD: begin
                isArith = 1'b1;
            end
            OP_SUB: begin
                bOperand = ~bus.b;
                carryIn  = 1'b1;
                isArith  = 1'b1;
            end
            default: begin
                bOperand = bus.b;
            end
        endcase
    end

    assign addFull    = {1'b0, bus.a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, carryIn};
    // Recover the carry into the MSB from the MSB sum bit and its two inputs
    assign msbCarryIn = addFull[WIDTH-1] ^ bus.a[WIDTH-1] ^ bOperand[WIDTH-1];

    // Result mux; unused op codes (001, 111) deliberately produce zero
    always_comb begin
        aluResult = '0;
        case (bus.cntrl)
            OP_PASS_B: aluResult = bus.b;
            OP_ADD,
            OP_SUB:    aluResult = addFull[WIDTH-1:0];
            OP_AND:    aluResult = bus.a & bus.b;
            OP_OR:     aluResult = bus.a | bus.b;
            OP_XOR:    aluResult = bus.a ^ bus.b;
            default:   aluResult = '0;
        endcase
    end

    // Flag generation; V and C only carry meaning for add/subtract
    always_comb begin
        flagN = aluResult[WIDTH-1];
        flagZ = (aluResult == '0);
        flagC = isArith & addFull[WIDTH];
        flagV = isArith & (msbCarryIn ^ addFull[WIDTH]);
    end

    // Result pipeline copy, loaded every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resultReg <= '0;
        end else begin
            resultReg <= aluResult;
        end
    end

    // NZVC flag register, loaded only when the instruction sets flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flagNReg <= 1'b0;
            flagZReg <= 1'b0;
            flagVReg <= 1'b0;
            flagCReg <= 1'b0;
        end else if (bus.flag_en) begin
            flagNReg <= flagN;
            flagZReg <= flagZ;
            flagVReg <= flagV;
            flagCReg <= flagC;
        end
    end

    assign bus.result    = aluResult;
    assign bus.negative  = flagN;
    assign bus.zero      = flagZ;
    assign bus.overflow  = flagV;
    assign bus.carry_out = flagC;

    assign bus.result_q  = resultReg;
    assign bus.flag_n_q  = flagNReg;
    assign bus.flag_z_q  = flagZReg;
    assign bus.flag_v_q  = flagVReg;
    assign bus.flag_c_q  = flagCReg;

    // Independent PC+4 / branch-target adder, wraps modulo 2^WIDTH
    assign bus.add_sum   = bus.add_a + bus.add_b;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed self-checking bench for alu_flag_unit.
module tb_alu_flag_unit;
    localparam int WIDTH = 64;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_flag_unit_if #(.WIDTH(WIDTH)) ifc ();

    alu_flag_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply ALU inputs and let the combinational outputs settle
    task automatic drive_alu(input logic [2:0] op, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic fe);
        ifc.cntrl   = op;
        ifc.a       = av;
        ifc.b       = bv;
        ifc.flag_en = fe;
        #1;
    endtask

    // Advance one rising edge and sample 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] regs;
        // Load nonzero state first: 0x7FFF..F + 1 sets N and V
        drive_alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        step();
        regs = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (regs !== 4'b1010) begin
            failures++;
            $display("FAIL preload_flags: got %b expected %b", regs, 4'b1010);
        end
        // Mid-cycle reset, no edge in between
        reset = 1'b1;
        #1;
        regs = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (ifc.result_q !== 64'h0) begin
            failures++;
            $display("FAIL async_reset_result_q: got %h expected 0", ifc.result_q);
        end
        checks++;
        if (regs !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_flags: got %b expected 0000", regs);
        end
        // Combinational path keeps working during reset
        checks++;
        if (ifc.result !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL result_during_reset: got %h expected %h", ifc.result, 64'h8000_0000_0000_0000);
        end
        // Held through an edge
        step();
        regs = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (ifc.result_q !== 64'h0 || regs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold: result_q %h flags %b expected 0 / 0000", ifc.result_q, regs);
        end
        // Release, flag_en = 0 with flag-producing operands
        reset = 1'b0;
        drive_alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        step();
        regs = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (regs !== 4'b0000) begin
            failures++;
            $display("FAIL flag_en_low_after_reset: got %b expected 0000", regs);
        end
        checks++;
        if (ifc.result_q !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL first_load_after_reset: got %h expected %h", ifc.result_q, 64'h8000_0000_0000_0000);
        end
    endtask

    task automatic test_add_overflow();
        logic [3:0] fl;
        drive_alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        fl = {ifc.negative, ifc.zero, ifc.overflow, ifc.carry_out};
        checks++;
        if (ifc.result !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL add_ovf_result: got %h expected %h", ifc.result, 64'h8000_0000_0000_0000);
        end
        checks++;
        if (fl !== 4'b1010) begin
            failures++;
            $display("FAIL add_ovf_flags: got %b expected 1010", fl);
        end
        ifc.flag_en = 1'b1;
        step();
        fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (fl !== 4'b1010) begin
            failures++;
            $display("FAIL add_ovf_flag_reg: got %b expected 1010", fl);
        end
    endtask

    task automatic test_add_carry();
        logic [3:0] fl;
        drive_alu(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        fl = {ifc.negative, ifc.zero, ifc.overflow, ifc.carry_out};
        checks++;
        if (ifc.result !== 64'h0) begin
            failures++;
            $display("FAIL add_wrap_result: got %h expected 0", ifc.result);
        end
        checks++;
        if (fl !== 4'b0101) begin
            failures++;
            $display("FAIL add_wrap_flags: got %b expected 0101", fl);
        end
        step();
        fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (fl !== 4'b0101) begin
            failures++;
            $display("FAIL add_wrap_flag_reg: got %b expected 0101", fl);
        end
    endtask

    task automatic test_subtract();
        logic [2:0]       op  [3];
        logic [WIDTH-1:0] av  [3];
        logic [WIDTH-1:0] bv  [3];
        logic [WIDTH-1:0] expR[3];
        logic [3:0]       expF[3];
        logic [3:0]       fl;
        av[0] = 64'd5; bv[0] = 64'd5; expR[0] = 64'h0;                   expF[0] = 4'b0101;
        av[1] = 64'd3; bv[1] = 64'd5; expR[1] = 64'hFFFF_FFFF_FFFF_FFFE; expF[1] = 4'b1000;
        av[2] = 64'h8000_0000_0000_0000; bv[2] = 64'd1;
        expR[2] = 64'h7FFF_FFFF_FFFF_FFFF; expF[2] = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            op[i] = 3'b011;
            drive_alu(op[i], av[i], bv[i], 1'b1);
            fl = {ifc.negative, ifc.zero, ifc.overflow, ifc.carry_out};
            checks++;
            if (ifc.result !== expR[i]) begin
                failures++;
                $display("FAIL sub_result[%0d]: got %h expected %h", i, ifc.result, expR[i]);
            end
            checks++;
            if (fl !== expF[i]) begin
                failures++;
                $display("FAIL sub_flags[%0d]: got %b expected %b", i, fl, expF[i]);
            end
            step();
            fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
            checks++;
            if (fl !== expF[i] || ifc.result_q !== expR[i]) begin
                failures++;
                $display("FAIL sub_regs[%0d]: flags %b result_q %h expected %b %h", i, fl, ifc.result_q, expF[i], expR[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0]       op  [6];
        logic [WIDTH-1:0] expR[6];
        logic [3:0]       fl;
        op[0] = 3'b100; expR[0] = 64'hF000;
        op[1] = 3'b101; expR[1] = 64'hFFF0;
        op[2] = 3'b110; expR[2] = 64'h0FF0;
        op[3] = 3'b000; expR[3] = 64'hFF00;
        op[4] = 3'b001; expR[4] = 64'h0;
        op[5] = 3'b111; expR[5] = 64'h0;
        for (int i = 0; i < 6; i++) begin
            drive_alu(op[i], 64'hF0F0, 64'hFF00, 1'b0);
            fl = {ifc.negative, ifc.zero, ifc.overflow, ifc.carry_out};
            checks++;
            if (ifc.result !== expR[i]) begin
                failures++;
                $display("FAIL logic_result op=%b: got %h expected %h", op[i], ifc.result, expR[i]);
            end
            checks++;
            if (fl !== {1'b0, (i >= 4), 2'b00}) begin
                failures++;
                $display("FAIL logic_flags op=%b: got %b expected %b", op[i], fl, {1'b0, (i >= 4), 2'b00});
            end
            step();
            checks++;
            if (ifc.result_q !== expR[i]) begin
                failures++;
                $display("FAIL logic_result_q op=%b: got %h expected %h", op[i], ifc.result_q, expR[i]);
            end
        end
        // Negative logic result: top bit set through XOR
        drive_alu(3'b110, 64'h8000_0000_0000_0001, 64'h1, 1'b0);
        fl = {ifc.negative, ifc.zero, ifc.overflow, ifc.carry_out};
        checks++;
        if (fl !== 4'b1000) begin
            failures++;
            $display("FAIL xor_negative_flags: got %b expected 1000", fl);
        end
    endtask

    task automatic test_flag_hold();
        logic [3:0] fl;
        // Load Z,C from a wrapping add, then hold while inputs change
        drive_alu(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        step();
        drive_alu(3'b011, 64'd3, 64'd5, 1'b0);
        step();
        step();
        fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (fl !== 4'b0101) begin
            failures++;
            $display("FAIL flag_hold: got %b expected 0101", fl);
        end
        checks++;
        if (ifc.result_q !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            failures++;
            $display("FAIL result_q_no_enable: got %h expected %h", ifc.result_q, 64'hFFFF_FFFF_FFFF_FFFE);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] fl;
        // Two consecutive flag-setting ops, each visible after its own edge
        drive_alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        step();
        drive_alu(3'b011, 64'd5, 64'd5, 1'b1);
        fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (fl !== 4'b1010) begin
            failures++;
            $display("FAIL b2b_first: got %b expected 1010", fl);
        end
        step();
        fl = {ifc.flag_n_q, ifc.flag_z_q, ifc.flag_v_q, ifc.flag_c_q};
        checks++;
        if (fl !== 4'b0101 || ifc.result_q !== 64'h0) begin
            failures++;
            $display("FAIL b2b_second: flags %b result_q %h expected 0101 0", fl, ifc.result_q);
        end
    endtask

    task automatic test_adder();
        ifc.add_a = 64'h100;
        ifc.add_b = 64'hFFFF_FFFF_FFFF_FFF8;
        ifc.cntrl = 3'b101;
        #1;
        checks++;
        if (ifc.add_sum !== 64'hF8) begin
            failures++;
            $display("FAIL adder_neg: got %h expected %h", ifc.add_sum, 64'hF8);
        end
        ifc.add_a = 64'h40;
        ifc.add_b = 64'h4;
        ifc.cntrl = 3'b011;
        #1;
        checks++;
        if (ifc.add_sum !== 64'h44) begin
            failures++;
            $display("FAIL adder_pc4: got %h expected %h", ifc.add_sum, 64'h44);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ifc.a       = '0;
        ifc.b       = '0;
        ifc.cntrl   = 3'b000;
        ifc.flag_en = 1'b0;
        ifc.add_a   = '0;
        ifc.add_b   = '0;
        step();
        reset = 1'b0;
        #1;

        test_reset();
        test_add_overflow();
        test_add_carry();
        test_subtract();
        test_logic();
        test_flag_hold();
        test_back_to_back();
        test_adder();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
